truncon_sweep_ctrl: RTL and testbench

//  Sequencer for the combinational truncate/concatenate/compare datapath. On start, drives a

---
 rtl/truncon_sweep_ctrl_if.sv | 27 ++
 rtl/truncon_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_truncon_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/truncon_sweep_ctrl_if.sv
// Result stream between the sweep sequencer and its consumer.
// valid/ready handshake carrying one captured datapath sample.
interface truncon_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_in;
  logic [WIDTH-1:0] res_out;
  logic             res_equal;

  modport master (
    output res_valid,
    output res_in,
    output res_out,
    output res_equal,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_in,
    input  res_out,
    input  res_equal,
    output res_ready
  );
endinterface

// File: rtl/truncon_sweep_ctrl.sv
// Sweep sequencer for the truncate/concatenate/compare datapath.
// Drives first..last onto dp_in, settles, captures, streams results.
module truncon_sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] sweep_first,
  input  logic [WIDTH-1:0] sweep_last,
  output logic [WIDTH-1:0] dp_in,
  input  logic [WIDTH-1:0] dp_out,
  input  logic             dp_equal,
  truncon_sweep_ctrl_if.master res,
  output logic [WIDTH:0]   match_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_HOLD,
    S_FIN
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_dp_in;
  logic [WIDTH-1:0] w_dp_in_nx;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_last_nx;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nx;
  logic [WIDTH-1:0] r_res_in;
  logic [WIDTH-1:0] w_res_in_nx;
  logic [WIDTH-1:0] r_res_out;
  logic [WIDTH-1:0] w_res_out_nx;
  logic             r_res_eq;
  logic             w_res_eq_nx;
  logic             r_res_valid;
  logic             w_res_valid_nx;
  logic [WIDTH:0]   r_match;
  logic [WIDTH:0]   w_match_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic             r_done;
  logic             w_done_nx;
  logic             w_hs;

  assign w_hs = r_res_valid & res.res_ready;

  // Next-state and next-register values; abort wins in every active state.
  always_comb begin
    w_state_nx     = r_state;
    w_dp_in_nx     = r_dp_in;
    w_last_nx      = r_last;
    w_cnt_nx       = r_cnt;
    w_res_in_nx    = r_res_in;
    w_res_out_nx   = r_res_out;
    w_res_eq_nx    = r_res_eq;
    w_res_valid_nx = r_res_valid;
    w_match_nx     = r_match;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nx = S_DRIVE;
          w_dp_in_nx = sweep_first;
          w_last_nx  = sweep_last;
          w_cnt_nx   = CNT_LOAD;
          w_match_nx = '0;
          w_busy_nx  = 1'b1;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          w_state_nx     = S_IDLE;
          w_res_valid_nx = 1'b0;
          w_busy_nx      = 1'b0;
        end else if (r_cnt == 4'd0) begin
          w_state_nx     = S_HOLD;
          w_res_in_nx    = r_dp_in;
          w_res_out_nx   = dp_out;
          w_res_eq_nx    = dp_equal;
          w_res_valid_nx = 1'b1;
          w_match_nx     = r_match
                         + {{WIDTH{1'b0}}, dp_equal};
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nx     = S_IDLE;
          w_res_valid_nx = 1'b0;
          w_busy_nx      = 1'b0;
        end else if (w_hs) begin
          w_res_valid_nx = 1'b0;
          if (r_dp_in == r_last) begin
            w_state_nx = S_FIN;
          end else begin
            w_state_nx = S_DRIVE;
            w_dp_in_nx = r_dp_in + 1'b1;
            w_cnt_nx   = CNT_LOAD;
          end
        end
      end
      S_FIN: begin
        w_state_nx     = S_IDLE;
        w_busy_nx      = 1'b0;
        w_res_valid_nx = 1'b0;
        w_done_nx      = !abort;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dp_in     <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_res_in    <= '0;
      r_res_out   <= '0;
      r_res_eq    <= 1'b0;
      r_res_valid <= 1'b0;
      r_match     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_dp_in     <= w_dp_in_nx;
      r_last      <= w_last_nx;
      r_cnt       <= w_cnt_nx;
      r_res_in    <= w_res_in_nx;
      r_res_out   <= w_res_out_nx;
      r_res_eq    <= w_res_eq_nx;
      r_res_valid <= w_res_valid_nx;
      r_match     <= w_match_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  assign dp_in         = r_dp_in;
  assign res.res_valid = r_res_valid;
  assign res.res_in    = r_res_in;
  assign res.res_out   = r_res_out;
  assign res.res_equal = r_res_eq;
  assign match_count   = r_match;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_truncon_sweep_ctrl.sv
// Directed bench for truncon_sweep_ctrl with a nibble-swap datapath.
// Two instances: SETTLE=1 for sweeps, SETTLE=3 for spacing/reset.
module tb_truncon_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] first, last;
  logic [7:0] dp_in, dp_out;
  logic       dp_eq;
  logic [8:0] match;
  logic       busy, done;

  logic       start3, abort3;
  logic [7:0] first3, last3;
  logic [7:0] dp_in3, dp_out3;
  logic       dp_eq3;
  logic [8:0] match3;
  logic       busy3, done3;

  int total = 0;
  int bad   = 0;

  truncon_sweep_ctrl_if #(.WIDTH(8)) u_if1();
  truncon_sweep_ctrl_if #(.WIDTH(8)) u_if3();

  assign dp_out  = {dp_in[3:0], dp_in[7:4]};
  assign dp_eq   = (dp_out == dp_in);
  assign dp_out3 = {dp_in3[3:0], dp_in3[7:4]};
  assign dp_eq3  = (dp_out3 == dp_in3);

  truncon_sweep_ctrl #(.WIDTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .sweep_first(first), .sweep_last(last),
    .dp_in(dp_in), .dp_out(dp_out), .dp_equal(dp_eq),
    .res(u_if1),
    .match_count(match), .busy(busy), .done(done)
  );

  truncon_sweep_ctrl #(.WIDTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .start(start3), .abort(abort3),
    .sweep_first(first3), .sweep_last(last3),
    .dp_in(dp_in3), .dp_out(dp_out3), .dp_equal(dp_eq3),
    .res(u_if3),
    .match_count(match3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] sw(input logic [7:0] v);
    return {v[3:0], v[7:4]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] f;
    logic [7:0] l;
    int         n;
    int         m;
  } vec_t;

  vec_t tbl[6];

  task automatic run_sweep(input vec_t t);
    logic [7:0] v;
    int n, fc, dn;
    @(negedge clk);
    first = t.f; last = t.l;
    start = 1'b1; u_if1.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("dp_first", dp_in, t.f);
    chk("valid_early", u_if1.res_valid, 0);
    v = t.f; n = 0; fc = -1; dn = 0;
    for (int c = 1; c <= 600 && dn == 0; c++) begin
      @(negedge clk);
      if (u_if1.res_valid) begin
        if (fc < 0) fc = c;
        chk("res_in", u_if1.res_in, v);
        chk("res_out", u_if1.res_out, sw(v));
        chk("res_eq", u_if1.res_equal,
            32'(sw(v) == v));
        n++;
        v = v + 8'd1;
      end
      if (done) dn = 1;
    end
    chk("done_seen", dn, 1);
    chk("n_results", n, t.n);
    chk("first_lat", fc, 1);
    chk("match", match, t.m);
    chk("busy_off", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("match_hold", match, t.m);
  endtask

  int cap[2];
  int n3, dn;

  initial begin
    rst_n = 1'b0;
    start = 0; abort = 0; first = 0; last = 0;
    start3 = 0; abort3 = 0; first3 = 0; last3 = 0;
    u_if1.res_ready = 1'b0;
    u_if3.res_ready = 1'b0;
    tbl[0] = '{8'hCC, 8'hCC, 1, 1};
    tbl[1] = '{8'hAA, 8'hAB, 2, 1};
    tbl[2] = '{8'hFE, 8'h01, 4, 2};
    tbl[3] = '{8'h12, 8'h15, 4, 0};
    tbl[4] = '{8'h00, 8'hFF, 256, 16};
    tbl[5] = '{8'hEE, 8'hEE, 1, 1};

    repeat (2) @(negedge clk);
    chk("rst_dp", dp_in, 0);
    chk("rst_valid", u_if1.res_valid, 0);
    chk("rst_rin", u_if1.res_in, 0);
    chk("rst_rout", u_if1.res_out, 0);
    chk("rst_req", u_if1.res_equal, 0);
    chk("rst_match", match, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Backpressure: first result held while ready is low.
    @(negedge clk);
    first = 8'h55; last = 8'h56;
    start = 1'b1; u_if1.res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("bp_valid", u_if1.res_valid, 1);
    chk("bp_in", u_if1.res_in, 8'h55);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_v", u_if1.res_valid, 1);
      chk("bp_hold_in", u_if1.res_in, 8'h55);
      chk("bp_hold_dp", dp_in, 8'h55);
    end
    u_if1.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_v", u_if1.res_valid, 0);
    chk("bp_next_dp", dp_in, 8'h56);
    @(negedge clk);
    chk("bp2_v", u_if1.res_valid, 1);
    chk("bp2_in", u_if1.res_in, 8'h56);
    chk("bp2_out", u_if1.res_out, 8'h65);
    chk("bp2_eq", u_if1.res_equal, 0);
    dn = 0;
    for (int c = 0; c < 6 && dn == 0; c++) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    chk("bp_done", dn, 1);
    chk("bp_match", match, 1);

    // Abort in HOLD of the second result, then restart.
    @(negedge clk);
    first = 8'h10; last = 8'h1F;
    start = 1'b1; u_if1.res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ab_r1", u_if1.res_in, 8'h10);
    u_if1.res_ready = 1'b1;
    @(negedge clk);
    chk("ab_dp2", dp_in, 8'h11);
    u_if1.res_ready = 1'b0;
    @(negedge clk);
    chk("ab_v2", u_if1.res_valid, 1);
    chk("ab_r2", u_if1.res_in, 8'h11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", u_if1.res_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_dp", dp_in, 8'h11);
    chk("ab_match", match, 1);
    first = 8'h33; last = 8'h33;
    start = 1'b1; u_if1.res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_busy", busy, 1);
    chk("rs_match0", match, 0);
    chk("rs_dp", dp_in, 8'h33);
    @(negedge clk);
    chk("rs_v", u_if1.res_valid, 1);
    chk("rs_in", u_if1.res_in, 8'h33);
    chk("rs_out", u_if1.res_out, 8'h33);
    chk("rs_eq", u_if1.res_equal, 1);
    dn = 0;
    for (int c = 0; c < 6 && dn == 0; c++) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    chk("rs_done", dn, 1);
    chk("rs_match", match, 1);

    // Abort and start together in IDLE: start is dropped.
    @(negedge clk);
    first = 8'h77; last = 8'h77;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("as_busy", busy, 0);
    chk("as_dp", dp_in, 8'h33);
    @(negedge clk);
    chk("as_valid", u_if1.res_valid, 0);

    // SETTLE=3: spacing, ignored start, async reset.
    @(negedge clk);
    first3 = 8'h40; last3 = 8'h42;
    start3 = 1'b1; u_if3.res_ready = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("s3_busy", busy3, 1);
    chk("s3_dp", dp_in3, 8'h40);
    n3 = 0; cap[0] = -1; cap[1] = -1;
    for (int c = 1; c <= 20 && n3 < 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start3 = 1'b1; first3 = 8'h99; last3 = 8'h99;
      end else begin
        start3 = 1'b0;
      end
      if (u_if3.res_valid) begin
        chk("s3_in", u_if3.res_in, 8'h40 + 8'(n3));
        cap[n3] = c;
        n3++;
      end
    end
    chk("s3_cap0", cap[0], 3);
    chk("s3_cap1", cap[1], 7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dp", dp_in3, 0);
    chk("ar_valid", u_if3.res_valid, 0);
    chk("ar_rin", u_if3.res_in, 0);
    chk("ar_match", match3, 0);
    chk("ar_busy", busy3, 0);
    chk("ar_done", done3, 0);
    chk("ar_dp1", dp_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle", busy3, 0);
    chk("ar_idle_v", u_if3.res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
